// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes and the x0 register index.
package hazard_ctrl_pkg;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: counts up on inc_i, holds at all-ones, synchronous clear.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait/timeout, load-use bubbles, branch flushes.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_Rd,
  input  logic [4:0]       IFID_Rs1,
  input  logic [4:0]       IFID_Rs2,
  input  logic             EX_BranchTaken,
  input  logic             EXMEM_MemAccess,
  input  logic             DMEM_Ack,
  output logic             DMEM_Req,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IDEX_En,
  output logic             EXMEM_En,
  output logic             MEMWB_En,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             MEMWB_Bubble,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] Perf_StallCycles,
  output logic [CNT_W-1:0] Perf_LoadUse,
  output logic [CNT_W-1:0] Perf_Flushes,
`endif
  output logic             Mem_Error
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]      state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_stall;
  logic            load_use;
  logic            active;

  assign load_use = IDEX_MemRead && (IDEX_Rd != REG_X0) &&
                    ((IDEX_Rd == IFID_Rs1) || (IDEX_Rd == IFID_Rs2));
  assign active   = !Reset && (state_q != ST_ERROR);

  always_comb begin
    DMEM_Req     = 1'b0;
    Mem_Error    = 1'b0;
    mem_stall    = 1'b0;
    PC_En        = 1'b0;
    IFID_En      = 1'b0;
    IDEX_En      = 1'b0;
    EXMEM_En     = 1'b0;
    MEMWB_En     = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    MEMWB_Bubble = 1'b0;
    if (!Reset) begin
      case (state_q)
        ST_RUN: begin
          DMEM_Req  = EXMEM_MemAccess;
          mem_stall = EXMEM_MemAccess && !DMEM_Ack;
        end
        ST_MEM_WAIT: begin
          DMEM_Req  = 1'b1;
          mem_stall = !DMEM_Ack;
        end
        ST_ERROR: Mem_Error = 1'b1;
        default: ;
      endcase
    end
    // Stall wins over everything; branch/load-use stay frozen upstream until release.
    if (active) begin
      if (mem_stall) begin
        MEMWB_En     = 1'b1;
        MEMWB_Bubble = 1'b1;
      end else if (EX_BranchTaken) begin
        {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b11111;
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (load_use) begin
        {IDEX_En, EXMEM_En, MEMWB_En} = 3'b111;
        IDEX_Flush = 1'b1;
      end else begin
        {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b11111;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (DMEM_Ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .CLK     (CLK),
    .clear_i (Reset),
    .inc_i   (active && mem_stall),
    .count_o (Perf_StallCycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
    .CLK     (CLK),
    .clear_i (Reset),
    .inc_i   (active && !mem_stall && !EX_BranchTaken && load_use),
    .count_o (Perf_LoadUse)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .CLK     (CLK),
    .clear_i (Reset),
    .inc_i   (active && !mem_stall && EX_BranchTaken),
    .count_o (Perf_Flushes)
  );
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; output vector order is
// {PC,IFID,IDEX,EXMEM,MEMWB En, IFID_Flush, IDEX_Flush, MEMWB_Bubble, DMEM_Req, Mem_Error}.
module tb_pipeline_hazard_ctrl;
  logic       CLK;
  logic       Reset;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rd;
  logic [4:0] IFID_Rs1;
  logic [4:0] IFID_Rs2;
  logic       EX_BranchTaken;
  logic       EXMEM_MemAccess;
  logic       DMEM_Ack;
  logic       DMEM_Req, PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En;
  logic       IFID_Flush, IDEX_Flush, MEMWB_Bubble, Mem_Error;
`ifdef HAZARD_PERF_EN
  logic [31:0] Perf_StallCycles, Perf_LoadUse, Perf_Flushes;
`endif

  int checks = 0;
  int passes = 0;
  logic [9:0] obs;

  localparam logic [9:0] V_ZERO   = 10'b00000_000_0_0;
  localparam logic [9:0] V_NORM   = 10'b11111_000_0_0;
  localparam logic [9:0] V_NORMRQ = 10'b11111_000_1_0;
  localparam logic [9:0] V_STALL  = 10'b00001_001_1_0;
  localparam logic [9:0] V_LU     = 10'b00111_010_0_0;
  localparam logic [9:0] V_BR     = 10'b11111_110_0_0;
  localparam logic [9:0] V_BRRQ   = 10'b11111_110_1_0;
  localparam logic [9:0] V_ERR    = 10'b00000_000_0_1;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .IDEX_MemRead    (IDEX_MemRead),
    .IDEX_Rd         (IDEX_Rd),
    .IFID_Rs1        (IFID_Rs1),
    .IFID_Rs2        (IFID_Rs2),
    .EX_BranchTaken  (EX_BranchTaken),
    .EXMEM_MemAccess (EXMEM_MemAccess),
    .DMEM_Ack        (DMEM_Ack),
    .DMEM_Req        (DMEM_Req),
    .PC_En           (PC_En),
    .IFID_En         (IFID_En),
    .IDEX_En         (IDEX_En),
    .EXMEM_En        (EXMEM_En),
    .MEMWB_En        (MEMWB_En),
    .IFID_Flush      (IFID_Flush),
    .IDEX_Flush      (IDEX_Flush),
    .MEMWB_Bubble    (MEMWB_Bubble),
`ifdef HAZARD_PERF_EN
    .Perf_StallCycles(Perf_StallCycles),
    .Perf_LoadUse    (Perf_LoadUse),
    .Perf_Flushes    (Perf_Flushes),
`endif
    .Mem_Error       (Mem_Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] outs();
    return {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En,
            IFID_Flush, IDEX_Flush, MEMWB_Bubble, DMEM_Req, Mem_Error};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    IDEX_MemRead = 0; IDEX_Rd = 0; IFID_Rs1 = 0; IFID_Rs2 = 0;
    EX_BranchTaken = 0; EXMEM_MemAccess = 0; DMEM_Ack = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    EXMEM_MemAccess = 1; EX_BranchTaken = 1; IDEX_MemRead = 1; IDEX_Rd = 3; IFID_Rs1 = 3;
    tick(); tick();
    obs = outs(); checks++;
    if (obs !== V_ZERO) $display("FAIL reset_outputs: got %b want %b", obs, V_ZERO);
    else passes++;
    Reset = 0; idle_inputs();
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL reset_release: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
  endtask

  task automatic test_zero_wait();
    EXMEM_MemAccess = 1; DMEM_Ack = 1;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORMRQ) $display("FAIL zero_wait: got %b want %b", obs, V_NORMRQ);
    else passes++;
    tick();
    EXMEM_MemAccess = 0; DMEM_Ack = 0;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL zero_wait_after: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
  endtask

  task automatic test_mem_wait();
    EXMEM_MemAccess = 1; DMEM_Ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      obs = outs(); checks++;
      if (obs !== V_STALL) $display("FAIL mem_wait_stall c%0d: got %b want %b", i, obs, V_STALL);
      else passes++;
      tick();
    end
    DMEM_Ack = 1;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORMRQ) $display("FAIL mem_wait_ack: got %b want %b", obs, V_NORMRQ);
    else passes++;
    tick();
    EXMEM_MemAccess = 0; DMEM_Ack = 0;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL mem_wait_back_run: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
  endtask

  task automatic test_load_use();
    IDEX_MemRead = 1; IDEX_Rd = 5; IFID_Rs1 = 7; IFID_Rs2 = 5;
    #1;
    obs = outs(); checks++;
    if (obs !== V_LU) $display("FAIL load_use_rs2: got %b want %b", obs, V_LU);
    else passes++;
    tick();
    IDEX_MemRead = 0; IDEX_Rd = 0;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL load_use_one_cycle: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
    IDEX_MemRead = 1; IDEX_Rd = 5'd5; IFID_Rs1 = 5'd21; IFID_Rs2 = 5'd13;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL load_use_bit4_differs: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
    IFID_Rs1 = 5'd5;
    #1;
    obs = outs(); checks++;
    if (obs !== V_LU) $display("FAIL load_use_rs1: got %b want %b", obs, V_LU);
    else passes++;
    tick();
    IDEX_MemRead = 0;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL load_use_not_load: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    IDEX_MemRead = 1; IDEX_Rd = 0; IFID_Rs1 = 0; IFID_Rs2 = 0;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL rd_x0_no_stall: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_priority();
    IDEX_MemRead = 1; IDEX_Rd = 9; IFID_Rs1 = 9; EX_BranchTaken = 1;
    #1;
    obs = outs(); checks++;
    if (obs !== V_BR) $display("FAIL branch_over_load_use: got %b want %b", obs, V_BR);
    else passes++;
    tick();
    idle_inputs();
  endtask

  task automatic test_branch_during_wait();
    EXMEM_MemAccess = 1; DMEM_Ack = 0; EX_BranchTaken = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      obs = outs(); checks++;
      if (obs !== V_STALL) $display("FAIL branch_wait_frozen c%0d: got %b want %b", i, obs, V_STALL);
      else passes++;
      tick();
    end
    DMEM_Ack = 1;
    #1;
    obs = outs(); checks++;
    if (obs !== V_BRRQ) $display("FAIL branch_after_release: got %b want %b", obs, V_BRRQ);
    else passes++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    EXMEM_MemAccess = 1; DMEM_Ack = 0;
    tick();
    Reset = 1;
    #1;
    obs = outs(); checks++;
    if (obs !== V_ZERO) $display("FAIL reset_mid_access: got %b want %b", obs, V_ZERO);
    else passes++;
    tick();
    Reset = 0; EXMEM_MemAccess = 0;
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL reset_mid_access_run: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
  endtask

  task automatic test_timeout();
    EXMEM_MemAccess = 1; DMEM_Ack = 0;
    // One RUN cycle plus MEM_TIMEOUT cycles in MEM_WAIT before ERROR.
    for (int i = 0; i < 17; i++) begin
      #1;
      obs = outs(); checks++;
      if (obs !== V_STALL) $display("FAIL timeout_stall c%0d: got %b want %b", i, obs, V_STALL);
      else passes++;
      tick();
    end
    #1;
    obs = outs(); checks++;
    if (obs !== V_ERR) $display("FAIL timeout_error: got %b want %b", obs, V_ERR);
    else passes++;
    DMEM_Ack = 1; EX_BranchTaken = 1;
    tick();
    obs = outs(); checks++;
    if (obs !== V_ERR) $display("FAIL error_sticky: got %b want %b", obs, V_ERR);
    else passes++;
    Reset = 1;
    tick();
    Reset = 0; idle_inputs();
    #1;
    obs = outs(); checks++;
    if (obs !== V_NORM) $display("FAIL error_cleared: got %b want %b", obs, V_NORM);
    else passes++;
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_load_use();
    test_rd_zero();
    test_branch_priority();
    test_branch_during_wait();
    test_reset_mid_access();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
